// File: rtl/test_monitor.sv
// test_monitor: multi-channel test-completion monitor.
// Watches N_CH CPU execute stages for the terminating ECALL and latches a
// per-channel PASS/FAIL from a0 (x10). Runs are bounded by an optional cycle
// timeout. Reports aggregate done/pass and the details of the first failure.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   start                  1-cycle pulse: clear run state and begin (or restart) a run
//   timeout_limit          run cycle limit, 0 = unlimited
//   exec_valid/inst/pc/a0  per-channel execute-stage view; channel i at slice i
//   running, done, pass    run status decodes
//   ch_done, ch_pass       per-channel termination / pass flags
//   timed_out              run ended by timeout
//   fail_ch/pc/a0          first failure of the run (pc in bytes)
//   cycles                 cycles elapsed in current/last run (saturating)

// Per-channel trap detection and result latch.
module test_monitor_ch (
   input  logic        clock,
   input  logic        reset,
   input  logic        clr,        // start pulse: clear per-run state
   input  logic        run,        // in RUN and not restarting this edge
   input  logic        tmo,        // timeout fires on this edge
   input  logic        exec_valid,
   input  logic [31:0] exec_inst,
   input  logic [29:0] exec_pc,
   input  logic [31:0] exec_a0,
   output logic        trap_fail,  // ECALL with nonzero a0 this cycle
   output logic        tmo_fail,   // channel is being timed out this cycle
   output logic        done_nxt,   // ch_done as it will be after this edge
   output logic [31:0] pc_byte,    // most recent valid PC, byte address
   output logic        ch_done,
   output logic        ch_pass
);
   logic        trap;
   logic [29:0] last_pc;
   logic        unused_bits;

   // ECALL is identified by inst[31:2] only; the low opcode bits are always 2'b11.
   assign unused_bits = ^exec_inst[1:0];

   assign trap      = run && exec_valid && (exec_inst[31:2] == 30'b11100) && !ch_done;
   assign trap_fail = trap && (exec_a0 != 32'd0);
   // A trap on the same cycle as the timeout takes precedence.
   assign tmo_fail  = run && tmo && !ch_done && !trap;
   assign done_nxt  = ch_done || trap || tmo_fail;
   assign pc_byte   = {(run && exec_valid) ? exec_pc : last_pc, 2'b00};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ch_done <= 1'b0;
         ch_pass <= 1'b0;
         last_pc <= '0;
      end else if (clr) begin
         ch_done <= 1'b0;
         ch_pass <= 1'b0;
         last_pc <= '0;
      end else if (run) begin
         if (exec_valid) last_pc <= exec_pc;
         if (trap) begin
            ch_done <= 1'b1;
            ch_pass <= (exec_a0 == 32'd0);
         end else if (tmo_fail) begin
            ch_done <= 1'b1;
            ch_pass <= 1'b0;
         end
      end
   end
endmodule

module test_monitor #(
   parameter int N_CH     = 1,
   parameter int CNT_W    = 16,
   parameter int STOP_ALL = 0,
   localparam int FW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_W-1:0]     timeout_limit,
   input  logic [N_CH-1:0]      exec_valid,
   input  logic [N_CH*32-1:0]   exec_inst,
   input  logic [N_CH*30-1:0]   exec_pc,
   input  logic [N_CH*32-1:0]   exec_a0,
   output logic                 running,
   output logic [N_CH-1:0]      ch_done,
   output logic [N_CH-1:0]      ch_pass,
   output logic                 done,
   output logic                 pass,
   output logic                 timed_out,
   output logic [FW-1:0]        fail_ch,
   output logic [31:0]          fail_pc,
   output logic [31:0]          fail_a0,
   output logic [CNT_W-1:0]     cycles
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            state;
   logic              fail_rec;
   logic              run, tmo;
   logic [N_CH-1:0]   trap_fail, tmo_fail, done_nxt;
   logic [31:0]       pc_b [N_CH];
   logic              sel_hit;
   logic [FW-1:0]     sel_idx;
   logic [31:0]       sel_pc, sel_a0;

   // start wins over any exec activity on the same edge.
   assign run = (state == RUN) && !start;
   assign tmo = (timeout_limit != '0) && (cycles == timeout_limit - ONE);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      test_monitor_ch u_ch (
         .clock      (clock),
         .reset      (reset),
         .clr        (start),
         .run        (run),
         .tmo        (tmo),
         .exec_valid (exec_valid[g]),
         .exec_inst  (exec_inst[32*g +: 32]),
         .exec_pc    (exec_pc[30*g +: 30]),
         .exec_a0    (exec_a0[32*g +: 32]),
         .trap_fail  (trap_fail[g]),
         .tmo_fail   (tmo_fail[g]),
         .done_nxt   (done_nxt[g]),
         .pc_byte    (pc_b[g]),
         .ch_done    (ch_done[g]),
         .ch_pass    (ch_pass[g])
      );
   end

   // First-failure select: trap failures outrank timeouts, lowest index wins.
   // Loops run high-to-low so the last assignment is the lowest index.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_pc  = '0;
      sel_a0  = '0;
      for (int i = N_CH-1; i >= 0; i--) begin
         if (tmo_fail[i]) begin
            sel_hit = 1'b1;
            sel_idx = FW'(i);
            sel_pc  = pc_b[i];
            sel_a0  = exec_a0[32*i +: 32];
         end
      end
      for (int i = N_CH-1; i >= 0; i--) begin
         if (trap_fail[i]) begin
            sel_hit = 1'b1;
            sel_idx = FW'(i);
            sel_pc  = pc_b[i];
            sel_a0  = exec_a0[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         fail_rec  <= 1'b0;
         timed_out <= 1'b0;
         fail_ch   <= '0;
         fail_pc   <= '0;
         fail_a0   <= '0;
         cycles    <= '0;
      end else if (start) begin
         state     <= RUN;
         fail_rec  <= 1'b0;
         timed_out <= 1'b0;
         fail_ch   <= '0;
         fail_pc   <= '0;
         fail_a0   <= '0;
         cycles    <= '0;
      end else if (state == RUN) begin
         if (cycles != {CNT_W{1'b1}}) cycles <= cycles + ONE;
         if (|tmo_fail) timed_out <= 1'b1;
         if (!fail_rec && sel_hit) begin
            fail_rec <= 1'b1;
            fail_ch  <= sel_idx;
            fail_pc  <= sel_pc;
            fail_a0  <= sel_a0;
         end
         if ((&done_nxt) || ((STOP_ALL != 0) && (fail_rec || sel_hit)))
            state <= DONE;
      end
   end

   assign running = (state == RUN);
   assign done    = (state == DONE);
   assign pass    = done && (&ch_pass);
endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;
   typedef struct packed {
      logic [3:0]  ch_done;
      logic [3:0]  ch_pass;
      logic        pass;
      logic        timed_out;
      logic [1:0]  fail_ch;
      logic [31:0] fail_pc;
      logic [31:0] fail_a0;
      logic [15:0] cycles;
   } exp_t;

   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBRK  = 32'h0010_0073;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: 4 channels, wait for all
   logic         st_a = 1'b0;
   logic [15:0]  lim_a = '0;
   logic [3:0]   ev_a = '0;
   logic [127:0] ei_a = '0;
   logic [119:0] ep_a = '0;
   logic [127:0] ea_a = '0;
   logic         run_a, done_a, pass_a, to_a;
   logic [3:0]   chd_a, chp_a;
   logic [1:0]   fch_a;
   logic [31:0]  fpc_a, fa0_a;
   logic [15:0]  cyc_a;

   // DUT B: 2 channels, stop on first failure
   logic         st_b = 1'b0;
   logic [15:0]  lim_b = '0;
   logic [1:0]   ev_b = '0;
   logic [63:0]  ei_b = '0;
   logic [59:0]  ep_b = '0;
   logic [63:0]  ea_b = '0;
   logic         run_b, done_b, pass_b, to_b;
   logic [1:0]   chd_b, chp_b;
   logic [0:0]   fch_b;
   logic [31:0]  fpc_b, fa0_b;
   logic [15:0]  cyc_b;

   test_monitor #(.N_CH(4), .CNT_W(16), .STOP_ALL(0)) u_a (
      .clock(clk), .reset(rst_n), .start(st_a), .timeout_limit(lim_a),
      .exec_valid(ev_a), .exec_inst(ei_a), .exec_pc(ep_a), .exec_a0(ea_a),
      .running(run_a), .ch_done(chd_a), .ch_pass(chp_a), .done(done_a),
      .pass(pass_a), .timed_out(to_a), .fail_ch(fch_a), .fail_pc(fpc_a),
      .fail_a0(fa0_a), .cycles(cyc_a));

   test_monitor #(.N_CH(2), .CNT_W(16), .STOP_ALL(1)) u_b (
      .clock(clk), .reset(rst_n), .start(st_b), .timeout_limit(lim_b),
      .exec_valid(ev_b), .exec_inst(ei_b), .exec_pc(ep_b), .exec_a0(ea_b),
      .running(run_b), .ch_done(chd_b), .ch_pass(chp_b), .done(done_b),
      .pass(pass_b), .timed_out(to_b), .fail_ch(fch_b), .fail_pc(fpc_b),
      .fail_a0(fa0_b), .cycles(cyc_b));

   int   n_chk = 0;
   int   n_pass = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic done_a_q = 1'b0, done_b_q = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic exp_t mk(input logic [3:0] d, input logic [3:0] p, input logic ps,
                               input logic t, input logic [1:0] fc, input logic [31:0] fp,
                               input logic [31:0] fa, input logic [15:0] c);
      exp_t e;
      e.ch_done = d; e.ch_pass = p; e.pass = ps; e.timed_out = t;
      e.fail_ch = fc; e.fail_pc = fp; e.fail_a0 = fa; e.cycles = c;
      return e;
   endfunction

   task automatic cmp(input string tag, input exp_t e, input exp_t a);
      chk({tag, "_ch_done"},   32'(a.ch_done),   32'(e.ch_done));
      chk({tag, "_ch_pass"},   32'(a.ch_pass),   32'(e.ch_pass));
      chk({tag, "_pass"},      32'(a.pass),      32'(e.pass));
      chk({tag, "_timed_out"}, 32'(a.timed_out), 32'(e.timed_out));
      chk({tag, "_fail_ch"},   32'(a.fail_ch),   32'(e.fail_ch));
      chk({tag, "_fail_pc"},   a.fail_pc,        e.fail_pc);
      chk({tag, "_fail_a0"},   a.fail_a0,        e.fail_a0);
      chk({tag, "_cycles"},    32'(a.cycles),    32'(e.cycles));
   endtask

   // Scoreboard monitors: pop one expectation on each rising done.
   always @(negedge clk) begin
      if (done_a && !done_a_q) begin
         if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_sb: done with no expectation queued");
         end else begin
            ea = qa.pop_front();
            cmp("A", ea, mk(chd_a, chp_a, pass_a, to_a, fch_a, fpc_a, fa0_a, cyc_a));
         end
      end
      done_a_q <= done_a;
   end

   always @(negedge clk) begin
      if (done_b && !done_b_q) begin
         if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_sb: done with no expectation queued");
         end else begin
            eb = qb.pop_front();
            cmp("B", eb, mk({2'b00, chd_b}, {2'b00, chp_b}, pass_b, to_b, {1'b0, fch_b},
                            fpc_b, fa0_b, cyc_b));
         end
      end
      done_b_q <= done_b;
   end

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_a(input int ch, input logic v, input logic [31:0] inst,
                        input logic [29:0] pc, input logic [31:0] a0);
      ev_a[ch] = v; ei_a[32*ch +: 32] = inst; ep_a[30*ch +: 30] = pc; ea_a[32*ch +: 32] = a0;
   endtask

   task automatic set_b(input int ch, input logic v, input logic [31:0] inst,
                        input logic [29:0] pc, input logic [31:0] a0);
      ev_b[ch] = v; ei_b[32*ch +: 32] = inst; ep_b[30*ch +: 30] = pc; ea_b[32*ch +: 32] = a0;
   endtask

   task automatic start_a;
      @(negedge clk) st_a = 1'b1;
      @(negedge clk) st_a = 1'b0;
   endtask

   task automatic start_b;
      @(negedge clk) st_b = 1'b1;
      @(negedge clk) st_b = 1'b0;
   endtask

   task automatic wait_done_a(input int budget);
      int k = 0;
      while (!done_a && k < budget) begin @(negedge clk); k++; end
      if (!done_a) begin n_chk++; $display("FAIL a_wait: done not seen within %0d cycles", budget); end
      adv(1);
   endtask

   task automatic wait_done_b(input int budget);
      int k = 0;
      while (!done_b && k < budget) begin @(negedge clk); k++; end
      if (!done_b) begin n_chk++; $display("FAIL b_wait: done not seen within %0d cycles", budget); end
      adv(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #3;
      chk("rst_running", 32'(run_a), 0);
      chk("rst_done",    32'(done_a), 0);
      chk("rst_ch_done", 32'(chd_a), 0);
      chk("rst_cycles",  32'(cyc_a), 0);
      chk("rst_b_done",  32'(done_b), 0);
      adv(2);
      rst_n = 1'b1;
      adv(1);

      // A1: all channels pass with ECALL presented at cycle 10
      qa.push_back(mk(4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 16'd11));
      start_a;
      chk("a1_running", 32'(run_a), 1);
      adv(10);
      for (int c = 0; c < 4; c++) set_a(c, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_a = '0;
      wait_done_a(20);

      // A2: ch0 fails a0=5 at word pc 0x40, others pass
      qa.push_back(mk(4'hF, 4'hE, 1'b0, 1'b0, 2'd0, 32'h100, 32'h5, 16'd4));
      start_a;
      adv(3);
      set_a(0, 1'b1, ECALL, 30'h40, 32'h5);
      for (int c = 1; c < 4; c++) set_a(c, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_a = '0;
      wait_done_a(20);

      // A3: ch1 (a0=7) and ch2 (a0=3) fail together; EBREAK and repeat ECALL ignored
      qa.push_back(mk(4'hF, 4'h9, 1'b0, 1'b0, 2'd1, 32'h40, 32'h7, 16'd7));
      start_a;
      adv(2);
      set_a(1, 1'b1, ECALL, 30'h10, 32'h7);
      set_a(2, 1'b1, ECALL, 30'h20, 32'h3);
      adv(1);
      ev_a = '0;
      set_a(0, 1'b1, EBRK, 30'h5, 32'h99);
      adv(1);
      ev_a = '0;
      set_a(1, 1'b1, ECALL, 30'h11, 32'h0);
      adv(1);
      ev_a = '0;
      chk("a3_still_running", 32'(run_a), 1);
      chk("a3_partial_done",  32'(chd_a), 32'h6);
      adv(1);
      set_a(0, 1'b1, ECALL, 30'h0, 32'h0);
      set_a(3, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_a = '0;
      wait_done_a(20);

      // A4: timeout at 100, ch3 passes early, ch0 last pc 0x30 with a0=0x1234
      lim_a = 16'd100;
      ea_a = '0;
      qa.push_back(mk(4'hF, 4'h8, 1'b0, 1'b1, 2'd0, 32'hC0, 32'h1234, 16'd100));
      start_a;
      set_a(0, 1'b0, NOP, 30'h0, 32'h1234);
      adv(5);
      set_a(3, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_a = '0;
      adv(1);
      set_a(0, 1'b1, NOP, 30'h30, 32'h1234);
      adv(1);
      ev_a = '0;
      wait_done_a(200);
      lim_a = '0;

      // Exec inputs ignored in DONE; cycles held
      set_a(1, 1'b1, ECALL, 30'h0, 32'h0);
      adv(2);
      ev_a = '0;
      chk("done_hold_ch_pass", 32'(chp_a), 32'h8);
      chk("done_hold_cycles",  32'(cyc_a), 32'd100);

      // Mid-run async reset clears everything without a clock edge
      start_a;
      adv(3);
      set_a(0, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_a = '0;
      chk("mid_ch_done", 32'(chd_a), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_running", 32'(run_a), 0);
      chk("arst_ch_done", 32'(chd_a), 0);
      chk("arst_ch_pass", 32'(chp_a), 0);
      chk("arst_cycles",  32'(cyc_a), 0);
      @(negedge clk) rst_n = 1'b1;

      // Exec ignored in IDLE
      set_a(0, 1'b1, ECALL, 30'h0, 32'h0);
      adv(2);
      ev_a = '0;
      chk("idle_ch_done", 32'(chd_a), 0);
      chk("idle_running", 32'(run_a), 0);

      // B1: STOP_ALL, ch1 fails at cycle 5 -> immediate done, ch0 untouched
      qb.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 2'd1, 32'h20, 32'h2, 16'd6));
      start_b;
      adv(5);
      set_b(1, 1'b1, ECALL, 30'h8, 32'h2);
      adv(1);
      ev_b = '0;
      wait_done_b(20);

      // Second start clears all results
      start_b;
      chk("b_restart_ch_done", 32'(chd_b), 0);
      chk("b_restart_fail_a0", fa0_b, 0);
      chk("b_restart_fail_ch", 32'(fch_b), 0);
      chk("b_restart_cycles",  32'(cyc_b), 0);
      chk("b_restart_running", 32'(run_b), 1);

      // B2: both channels pass
      qb.push_back(mk(4'h3, 4'h3, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 16'd3));
      adv(2);
      set_b(0, 1'b1, ECALL, 30'h0, 32'h0);
      set_b(1, 1'b1, ECALL, 30'h0, 32'h0);
      adv(1);
      ev_b = '0;
      wait_done_b(20);

      adv(2);
      if (qa.size() != 0 || qb.size() != 0) begin
         n_chk++;
         $display("FAIL sb_leftover: %0d/%0d expectations never matched", qa.size(), qb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
